// File: rtl/demux_dispatch_4ch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_dispatch_4ch_if : upstream handshake + demux drive bundle       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface demux_dispatch_4ch_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_dest;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        ch_ready;
    logic              sel0;
    logic              sel1;
    logic [DATA_W-1:0] out_data;
    logic              out_strobe;

    modport master (
        output in_valid, in_dest, in_data, ch_ready,
        input  in_ready, sel0, sel1, out_data, out_strobe
    );

    modport slave (
        input  in_valid, in_dest, in_data, ch_ready,
        output in_ready, sel0, sel1, out_data, out_strobe
    );
endinterface
`default_nettype wire

// File: rtl/demux_dispatch_4ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_dispatch_4ch : FIFO-buffered in-order feeder for a 1:4 demux    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module demux_dispatch_4ch #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    demux_dispatch_4ch_if.slave     bus,
    output logic [$clog2(DEPTH):0]  fifo_level_o,
    output logic [31:0]             cnt_flat_o
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(DEPTH);

    typedef logic [DATA_W+1:0] entry_t;

    entry_t              mem_q [DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [1:0]          sel_q, sel_d;
    logic                strobe_q, strobe_d;

    logic                w_push;
    logic                w_pop;
    entry_t              w_head;
    logic [1:0]          w_head_dest;

    // Both handshakes depend only on registered state: no bypass paths.
    assign w_head      = mem_q[rd_ptr_q];
    assign w_head_dest = w_head[DATA_W+1:DATA_W];
    assign w_push      = bus.in_valid && (level_q != c_FULL);
    assign w_pop       = (level_q != '0) && bus.ch_ready[w_head_dest];

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {bus.in_dest, bus.in_data};
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        out_data_d = out_data_q;
        sel_d      = sel_q;
        strobe_d   = 1'b0;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d   = rd_ptr_q + c_PTR_W'(1);
            out_data_d = w_head[DATA_W-1:0];
            sel_d      = w_head_dest;
            strobe_d   = 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + c_LVL_W'(1);
            2'b01:   level_d = level_q - c_LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            out_data_q <= '0;
            sel_q      <= 2'b00;
            strobe_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            out_data_q <= out_data_d;
            sel_q      <= sel_d;
            strobe_q   <= strobe_d;
        end
    end

    generate
        for (genvar k = 0; k < 4; k++) begin : g_cnt
            logic [7:0] cnt_q, cnt_d;

            // Saturating: holds at 255 rather than wrapping.
            always_comb begin
                cnt_d = cnt_q;
                if (w_pop && (w_head_dest == 2'(k)) && (cnt_q != 8'hFF)) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= 8'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_flat_o[8*k +: 8] = cnt_q;
        end
    endgenerate

    assign bus.in_ready   = (level_q != c_FULL);
    assign bus.sel0       = sel_q[1];
    assign bus.sel1       = sel_q[0];
    assign bus.out_data   = out_data_q;
    assign bus.out_strobe = strobe_q;
    assign fifo_level_o   = level_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_dispatch_4ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_demux_dispatch_4ch : scoreboard bench for demux_dispatch_4ch       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_demux_dispatch_4ch;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  fifo_level;
    logic [31:0] cnt_flat;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_strobes = 0;

    logic [9:0]  exp_q [$];
    int          exp_cnt [4];

    demux_dispatch_4ch_if #(.DATA_W(DATA_W)) ifc ();

    demux_dispatch_4ch #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (ifc.slave),
        .fifo_level_o (fifo_level),
        .cnt_flat_o   (cnt_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding item.
    always @(negedge clk) begin
        if (rst_n && ifc.out_strobe) begin
            n_strobes++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_strobe: got sel=%b%b data=%0h expected no strobe",
                         ifc.sel0, ifc.sel1, ifc.out_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({ifc.sel0, ifc.sel1, ifc.out_data} !== e) begin
                    n_errors++;
                    $display("FAIL dispatch: got sel=%b%b data=%0h expected sel=%b data=%0h",
                             ifc.sel0, ifc.sel1, ifc.out_data, e[9:8], e[7:0]);
                end
                if (exp_cnt[e[9:8]] < 255) exp_cnt[e[9:8]]++;
            end
        end
    end

    task automatic push(input logic [1:0] d, input logic [7:0] x);
        int t = 0;
        ifc.in_valid = 1'b1;
        ifc.in_dest  = d;
        ifc.in_data  = x;
        while (!ifc.in_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (t == 20) chk("push_timeout", 32'(t), 32'd0);
        @(posedge clk);
        exp_q.push_back({d, x});
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk); t++;
        end
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_cnts();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cnt%0d", k), 32'(cnt_flat[8*k +: 8]), 32'(exp_cnt[k]));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(ifc.in_ready), 32'd1);
        chk({tag, "_sel"}, 32'({ifc.sel0, ifc.sel1}), 32'd0);
        chk({tag, "_out_data"}, 32'(ifc.out_data), 32'd0);
        chk({tag, "_strobe"}, 32'(ifc.out_strobe), 32'd0);
        chk({tag, "_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_cnt_flat"}, cnt_flat, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        ifc.in_valid = 1'b0;
        ifc.in_dest  = 2'd0;
        ifc.in_data  = '0;
        ifc.ch_ready = 4'h0;
        #1 rst_n = 1'b0;
        #1 check_reset_vals("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single item, latency of two edges
        ifc.ch_ready = 4'hF;
        push(2'd2, 8'hA5);
        chk("lat_no_strobe_yet", 32'(ifc.out_strobe), 32'd0);
        @(posedge clk); #1;
        chk("lat_strobe", 32'(ifc.out_strobe), 32'd1);
        chk("lat_sel", 32'({ifc.sel0, ifc.sel1}), 32'b10);
        chk("lat_data", 32'(ifc.out_data), 32'hA5);
        @(posedge clk); #1;
        chk("strobe_one_cycle", 32'(ifc.out_strobe), 32'd0);
        chk("cnt2_one", 32'(cnt_flat[23:16]), 32'd1);

        // Fill to full with no channel ready
        ifc.ch_ready = 4'h0;
        for (int k = 0; k < DEPTH; k++) push(2'(k), 8'(8'h40 + k));
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_in_ready", 32'(ifc.in_ready), 32'd0);
        ifc.in_valid = 1'b1;
        ifc.in_dest  = 2'd1;
        ifc.in_data  = 8'hEE;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        chk("full_reject_level", 32'(fifo_level), 32'd4);
        ifc.ch_ready = 4'hF;
        drain();
        check_cnts();

        // Head-of-line blocking
        ifc.ch_ready = 4'b0001;
        push(2'd1, 8'h11);
        push(2'd0, 8'h22);
        s0 = n_strobes;
        repeat (3) @(posedge clk);
        #1;
        chk("hol_no_strobe", 32'(n_strobes - s0), 32'd0);
        chk("hol_level", 32'(fifo_level), 32'd2);
        ifc.ch_ready = 4'b0011;
        @(posedge clk); #1;
        chk("hol_first_strobe", 32'(ifc.out_strobe), 32'd1);
        chk("hol_first_sel", 32'({ifc.sel0, ifc.sel1}), 32'b01);
        @(posedge clk); #1;
        chk("hol_second_strobe", 32'(ifc.out_strobe), 32'd1);
        chk("hol_second_sel", 32'({ifc.sel0, ifc.sel1}), 32'b00);
        chk("hol_level_empty", 32'(fifo_level), 32'd0);
        drain();

        // Back-to-back throughput, ten items cycling destinations
        ifc.ch_ready = 4'hF;
        s0 = n_strobes;
        for (int i = 0; i < 10; i++) push(2'(i % 4), 8'(8'h30 + i));
        @(posedge clk);
        @(negedge clk); #1;
        chk("burst_strobes", 32'(n_strobes - s0), 32'd10);
        @(negedge clk); #1;
        chk("burst_no_extra", 32'(n_strobes - s0), 32'd10);
        drain();
        check_cnts();

        // Counter saturation on channel 3
        for (int i = 0; i < 300; i++) push(2'd3, 8'(i));
        drain();
        chk("cnt3_saturated", 32'(cnt_flat[31:24]), 32'd255);
        check_cnts();

        // Reset mid-operation with a strobe in flight
        ifc.ch_ready = 4'h0;
        for (int i = 0; i < 3; i++) push(2'd0, 8'(8'hC0 + i));
        ifc.ch_ready = 4'h1;
        @(posedge clk); #1;
        chk("pre_reset_strobe", 32'(ifc.out_strobe), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        ifc.ch_ready = 4'hF;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        s0 = n_strobes;
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_no_stale", 32'(n_strobes - s0), 32'd0);
        chk("post_reset_level", 32'(fifo_level), 32'd0);
        push(2'd1, 8'h5A);
        drain();
        check_cnts();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
